window_scan_ctrl: RTL and testbench
===================================

# window_scan_ctrl

Sequencer for the window sum datapath. On `start` it walks a WINDOW_WIDTH×WINDOW_HEIGHT window over an IMG_WIDTH×IMG_HEIGHT integral-image frame in raster order with stride STEP. For each position it streams the window's pixel addresses with end-of-row/end-of-window tags to the memory/window_sum path, then waits for the returned sum. It tags the sum with the window position and hands it to the classifier stage.

## Interface
Parameters:
- W_DATA, 26, input pixel width; the sum is W_DATA+2 bits
- IMG_WIDTH, 320, frame width in pixels
- IMG_HEIGHT, 240, frame height in pixels
- WINDOW_WIDTH, 24, window width
- WINDOW_HEIGHT, 24, window height
- STEP, 1, window stride in x and y

Ports. W_ADDR = $clog2(IMG_WIDTH*IMG_HEIGHT); W_X/W_Y = $clog2(IMG_WIDTH)/$clog2(IMG_HEIGHT).
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  frame start pulse; ignored unless IDLE
- busy  out  1  high from the cycle after accepted start until DONE
- done  out  1  one-cycle pulse when the last result is accepted
- addr_valid  out  1  address beat valid
- addr_ready  in  1  downstream accepts the beat
- addr_data  out  W_ADDR  pixel address = row*IMG_WIDTH+col
- addr_eot  out  2  01 = last pixel of a window row; 11 = last pixel of the window; 00 otherwise
- sum_valid  in  1  window sum available
- sum_ready  out  1  high only in WAIT_SUM
- sum_data  in  W_DATA+2  window sum
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- res_x  out  W_X  window left column
- res_y  out  W_Y  window top row
- res_sum  out  W_DATA+2  captured sum

## Operation
- FSM states: IDLE, STREAM, WAIT_SUM, RESULT, DONE.
- IDLE → STREAM on `start`. On entry: win_x=0, win_y=0, pix_col=0, pix_row=0.
- STREAM: addr_valid=1, addr_data=(win_y+pix_row)*IMG_WIDTH+(win_x+pix_col).
  - Each handshake (valid&ready) advances pix_col.
  - pix_col wraps at WINDOW_WIDTH-1 to 0 and increments pix_row.
  - On the handshake of beat (WW-1,WH-1), go to WAIT_SUM and clear the pix counters.
- WAIT_SUM: sum_ready=1. On sum_valid, capture sum_data, res_x=win_x, res_y=win_y, and go to RESULT.
- RESULT: res_valid=1. On res_ready, advance the window position:
  - win_x+=STEP if win_x+STEP+WINDOW_WIDTH ≤ IMG_WIDTH; else win_x=0, win_y+=STEP.
  - If win_y+STEP+WINDOW_HEIGHT > IMG_HEIGHT at wrap, go to DONE; else go to STREAM.
- DONE: done=1 for one cycle, then IDLE.
- Positions per frame: NX=(IMG_WIDTH-WINDOW_WIDTH)/STEP+1, NY=(IMG_HEIGHT-WINDOW_HEIGHT)/STEP+1. Trailing columns and rows that don't fit a full window are never visited.
- Address arithmetic is unsigned, W_ADDR bits, never overflows for legal parameters. Require WINDOW_WIDTH≤IMG_WIDTH and WINDOW_HEIGHT≤IMG_HEIGHT.
- `start` while busy: ignored, no state change.
- sum_valid outside WAIT_SUM: not consumed (sum_ready=0). Downstream must hold it.

## Timing
- Reset values: busy=0, done=0, addr_valid=0, addr_data=0, addr_eot=00, sum_ready=0, res_valid=0, res_x=0, res_y=0, res_sum=0. FSM in IDLE, all counters 0.
- All outputs are registered.
- First addr_valid appears 1 cycle after start is sampled.
- Throughput is 1 beat/cycle with addr_ready held high.
- Stall rule: while addr_valid && !addr_ready, addr_data and addr_eot are held stable.
- Stall rule: while res_valid && !res_ready, res_x, res_y and res_sum are held stable.
- Stall cycles: WAIT_SUM→RESULT costs 1 cycle. RESULT→STREAM costs 1 cycle (the first beat of the next window follows the res handshake by 1 cycle).
- rst mid-frame returns the block to the reset state on the next edge. No done pulse is issued and no partial result is emitted.

## Configuration
- Macro `WINDOW_SCAN_CTRL_CNT_EN`.
- Defined: adds output port `win_cnt` (width $clog2(NX*NY+1)).
  - Cleared on accepted start and on rst.
  - Incremented on each res handshake.
  - Holds NX*NY after done.
- Undefined: no port and no counter logic; behaviour is otherwise identical.

## Test plan
- IMG 26×25, window 24×24, STEP 1, ready always high, sum_valid returned 2 cycles into WAIT_SUM → 6 results, (x,y) in order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); 576 beats per window; done pulse after the 6th result; win_cnt=6 if enabled.
- Window 0 tag check → addr_eot=01 on beats 23,47,…,551; 11 on beat 575; first addr 0; last addr 23*26+23=621.
- Random addr_ready/res_ready backpressure (50%) → addr_data, addr_eot, res_* stable during stalls; addr sequence and result values identical to the no-stall run.
- IMG 30×24, window 24×24, STEP 4 → NX=2, NY=1; results at x=0 and x=4 only; done after 2 results.
- rst asserted in STREAM mid-window, then a new start → outputs at reset values after 1 cycle; rescan begins from (0,0) with pixel address 0.
- start pulsed during STREAM and during RESULT → ignored; result count and order unchanged.

Source files
------------

// File: rtl/window_scan_ctrl_if.sv
// rtl/window_scan_ctrl_if.sv - address, sum and result handshake bundle for window_scan_ctrl
interface window_scan_ctrl_if #(
  parameter int W_DATA     = 26,
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240
);
  localparam int W_ADDR = $clog2(IMG_WIDTH * IMG_HEIGHT);
  localparam int W_X    = $clog2(IMG_WIDTH);
  localparam int W_Y    = $clog2(IMG_HEIGHT);

  logic              addr_valid;
  logic              addr_ready;
  logic [W_ADDR-1:0] addr_data;
  logic [1:0]        addr_eot;
  logic              sum_valid;
  logic              sum_ready;
  logic [W_DATA+1:0] sum_data;
  logic              res_valid;
  logic              res_ready;
  logic [W_X-1:0]    res_x;
  logic [W_Y-1:0]    res_y;
  logic [W_DATA+1:0] res_sum;

  modport master (
    output addr_valid, addr_data, addr_eot, sum_ready, res_valid, res_x, res_y, res_sum,
    input  addr_ready, sum_valid, sum_data, res_ready
  );

  modport slave (
    input  addr_valid, addr_data, addr_eot, sum_ready, res_valid, res_x, res_y, res_sum,
    output addr_ready, sum_valid, sum_data, res_ready
  );
endinterface

// File: rtl/window_scan_ctrl.sv
// rtl/window_scan_ctrl.sv - raster window scan sequencer; WINDOW_SCAN_CTRL_CNT_EN adds win_cnt output
module window_scan_ctrl #(
  parameter int W_DATA        = 26,
  parameter int IMG_WIDTH     = 320,
  parameter int IMG_HEIGHT    = 240,
  parameter int WINDOW_WIDTH  = 24,
  parameter int WINDOW_HEIGHT = 24,
  parameter int STEP          = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  window_scan_ctrl_if.master bus
`ifdef WINDOW_SCAN_CTRL_CNT_EN
  ,
  output logic [$clog2(((IMG_WIDTH - WINDOW_WIDTH) / STEP + 1) *
                       ((IMG_HEIGHT - WINDOW_HEIGHT) / STEP + 1) + 1) - 1:0] win_cnt
`endif
);
  localparam int W_ADDR = $clog2(IMG_WIDTH * IMG_HEIGHT);
  localparam int W_X    = $clog2(IMG_WIDTH);
  localparam int W_Y    = $clog2(IMG_HEIGHT);
  localparam int W_SUM  = W_DATA + 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STREAM = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_RESULT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [W_X-1:0]    COL_LAST = W_X'(WINDOW_WIDTH - 1);
  localparam logic [W_Y-1:0]    ROW_LAST = W_Y'(WINDOW_HEIGHT - 1);
  localparam logic [W_X-1:0]    X_ONE    = W_X'(1);
  localparam logic [W_Y-1:0]    Y_ONE    = W_Y'(1);
  localparam logic [W_X-1:0]    X_STEP   = W_X'(STEP);
  localparam logic [W_Y-1:0]    Y_STEP   = W_Y'(STEP);
  localparam logic [W_ADDR-1:0] A_ONE    = W_ADDR'(1);
  // jump from the last pixel of a window row to the first pixel of the next row
  localparam logic [W_ADDR-1:0] A_ROW    = W_ADDR'(IMG_WIDTH - WINDOW_WIDTH + 1);
  localparam logic [W_ADDR-1:0] A_STEP   = W_ADDR'(STEP);
  localparam logic [W_ADDR-1:0] A_YSTEP  = W_ADDR'(STEP * IMG_WIDTH);
  localparam logic [1:0] EOT_FIRST = {(WINDOW_WIDTH == 1) && (WINDOW_HEIGHT == 1), WINDOW_WIDTH == 1};

  logic [2:0]        state;
  logic [W_X-1:0]    win_x;
  logic [W_Y-1:0]    win_y;
  logic [W_X-1:0]    pix_col;
  logic [W_Y-1:0]    pix_row;
  logic [W_ADDR-1:0] row_base;
  logic              x_fits;
  logic              y_fits;
  logic              col_last;
  logic              beat_last;

  function automatic logic [1:0] eot_for(input logic [W_X-1:0] col, input logic [W_Y-1:0] row);
    return {(col == COL_LAST) && (row == ROW_LAST), col == COL_LAST};
  endfunction

  assign x_fits    = (32'(win_x) + STEP + WINDOW_WIDTH) <= IMG_WIDTH;
  assign y_fits    = (32'(win_y) + STEP + WINDOW_HEIGHT) <= IMG_HEIGHT;
  assign col_last  = (pix_col == COL_LAST);
  assign beat_last = col_last && (pix_row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      win_x          <= '0;
      win_y          <= '0;
      pix_col        <= '0;
      pix_row        <= '0;
      row_base       <= '0;
      bus.addr_valid <= 1'b0;
      bus.addr_data  <= '0;
      bus.addr_eot   <= 2'b00;
      bus.sum_ready  <= 1'b0;
      bus.res_valid  <= 1'b0;
      bus.res_x      <= '0;
      bus.res_y      <= '0;
      bus.res_sum    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state          <= S_STREAM;
            busy           <= 1'b1;
            win_x          <= '0;
            win_y          <= '0;
            pix_col        <= '0;
            pix_row        <= '0;
            row_base       <= '0;
            bus.addr_valid <= 1'b1;
            bus.addr_data  <= '0;
            bus.addr_eot   <= EOT_FIRST;
          end
        end
        S_STREAM: begin
          if (bus.addr_ready) begin
            if (beat_last) begin
              state          <= S_WAIT;
              pix_col        <= '0;
              pix_row        <= '0;
              bus.addr_valid <= 1'b0;
              bus.addr_eot   <= 2'b00;
              bus.sum_ready  <= 1'b1;
            end else if (col_last) begin
              pix_col       <= '0;
              pix_row       <= pix_row + Y_ONE;
              bus.addr_data <= bus.addr_data + A_ROW;
              bus.addr_eot  <= eot_for('0, pix_row + Y_ONE);
            end else begin
              pix_col       <= pix_col + X_ONE;
              bus.addr_data <= bus.addr_data + A_ONE;
              bus.addr_eot  <= eot_for(pix_col + X_ONE, pix_row);
            end
          end
        end
        S_WAIT: begin
          if (bus.sum_valid) begin
            state         <= S_RESULT;
            bus.sum_ready <= 1'b0;
            bus.res_valid <= 1'b1;
            bus.res_sum   <= W_SUM'(bus.sum_data);
            bus.res_x     <= win_x;
            bus.res_y     <= win_y;
          end
        end
        S_RESULT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            if (x_fits) begin
              state          <= S_STREAM;
              win_x          <= win_x + X_STEP;
              bus.addr_valid <= 1'b1;
              bus.addr_data  <= row_base + W_ADDR'(win_x) + A_STEP;
              bus.addr_eot   <= EOT_FIRST;
            end else if (y_fits) begin
              state          <= S_STREAM;
              win_x          <= '0;
              win_y          <= win_y + Y_STEP;
              row_base       <= row_base + A_YSTEP;
              bus.addr_valid <= 1'b1;
              bus.addr_data  <= row_base + A_YSTEP;
              bus.addr_eot   <= EOT_FIRST;
            end else begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef WINDOW_SCAN_CTRL_CNT_EN
  localparam int CNT_W = $bits(win_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      win_cnt <= '0;
    end else if (state == S_RESULT && bus.res_ready) begin
      win_cnt <= win_cnt + CNT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_window_scan_ctrl.sv
// tb/tb_window_scan_ctrl.sv - directed self-checking bench for window_scan_ctrl
module tb_window_scan_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic a_start, b_start, sel;
  logic addr_ready, sum_valid, res_ready;
  logic [27:0] sum_data;
  logic a_busy, a_done, b_busy, b_done;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  window_scan_ctrl_if #(.W_DATA(26), .IMG_WIDTH(26), .IMG_HEIGHT(25)) a_if ();
  window_scan_ctrl_if #(.W_DATA(26), .IMG_WIDTH(30), .IMG_HEIGHT(24)) b_if ();

`ifdef WINDOW_SCAN_CTRL_CNT_EN
  logic [2:0] a_cnt;
  logic [1:0] b_cnt;
`endif

  window_scan_ctrl #(
    .W_DATA(26), .IMG_WIDTH(26), .IMG_HEIGHT(25),
    .WINDOW_WIDTH(24), .WINDOW_HEIGHT(24), .STEP(1)
  ) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done), .bus(a_if)
`ifdef WINDOW_SCAN_CTRL_CNT_EN
    , .win_cnt(a_cnt)
`endif
  );

  window_scan_ctrl #(
    .W_DATA(26), .IMG_WIDTH(30), .IMG_HEIGHT(24),
    .WINDOW_WIDTH(24), .WINDOW_HEIGHT(24), .STEP(4)
  ) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done), .bus(b_if)
`ifdef WINDOW_SCAN_CTRL_CNT_EN
    , .win_cnt(b_cnt)
`endif
  );

  assign a_if.addr_ready = addr_ready;
  assign a_if.sum_valid  = sum_valid;
  assign a_if.sum_data   = sum_data;
  assign a_if.res_ready  = res_ready;
  assign b_if.addr_ready = addr_ready;
  assign b_if.sum_valid  = sum_valid;
  assign b_if.sum_data   = sum_data;
  assign b_if.res_ready  = res_ready;

  logic        o_addr_valid, o_sum_ready, o_res_valid, o_busy, o_done;
  logic [9:0]  o_addr;
  logic [1:0]  o_eot;
  logic [4:0]  o_res_x, o_res_y;
  logic [27:0] o_res_sum;

  assign o_addr_valid = sel ? b_if.addr_valid : a_if.addr_valid;
  assign o_addr       = sel ? b_if.addr_data  : a_if.addr_data;
  assign o_eot        = sel ? b_if.addr_eot   : a_if.addr_eot;
  assign o_sum_ready  = sel ? b_if.sum_ready  : a_if.sum_ready;
  assign o_res_valid  = sel ? b_if.res_valid  : a_if.res_valid;
  assign o_res_x      = sel ? b_if.res_x      : a_if.res_x;
  assign o_res_y      = sel ? b_if.res_y      : a_if.res_y;
  assign o_res_sum    = sel ? b_if.res_sum    : a_if.res_sum;
  assign o_busy       = sel ? b_busy          : a_busy;
  assign o_done       = sel ? b_done          : a_done;

  function automatic logic [27:0] sum_of(input int k);
    return 28'h9A0_0000 + 28'(k * 7919);
  endfunction

  // Drives one full frame on the selected DUT; the 24x24 window is common to both DUTs.
  task automatic run_scan(input bit use_b, input int iw, input int nx, input int ny, input int step,
                          input bit bp, input bit poke, input string tag);
    int beat, k, wait_cnt, r, c, ex, ey, exp_addr, exp_eot;
    bit stall_a, stall_r, fin, pk;
    logic [9:0] h_addr;
    logic [1:0] h_eot;
    logic [4:0] h_x, h_y;
    logic [27:0] h_sum;
    sel = use_b;
    addr_ready = 1'b1; res_ready = 1'b0; sum_valid = 1'b0; sum_data = '0;
    if (use_b) b_start = 1'b1; else a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0; b_start = 1'b0;
    checks++;
    if (o_addr_valid !== 1'b1 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s first_beat: valid=%b busy=%b, want 1 1", tag, o_addr_valid, o_busy);
    end
    beat = 0; k = 0; wait_cnt = 0; stall_a = 0; stall_r = 0; fin = 0;
    h_addr = '0; h_eot = '0; h_x = '0; h_y = '0; h_sum = '0;
    for (int cyc = 0; cyc < 30000 && !fin; cyc++) begin
      if (stall_a) begin
        checks++;
        if (o_addr_valid !== 1'b1 || o_addr !== h_addr || o_eot !== h_eot) begin
          errors++;
          $display("FAIL %s addr_hold: v=%b addr=%0d eot=%b, want 1 %0d %b", tag, o_addr_valid, o_addr, o_eot, h_addr, h_eot);
        end
      end
      if (stall_r) begin
        checks++;
        if (o_res_valid !== 1'b1 || o_res_x !== h_x || o_res_y !== h_y || o_res_sum !== h_sum) begin
          errors++;
          $display("FAIL %s res_hold: v=%b x=%0d y=%0d sum=%h, want 1 %0d %0d %h", tag, o_res_valid, o_res_x, o_res_y, o_res_sum, h_x, h_y, h_sum);
        end
      end
      ex = (k % nx) * step;
      ey = (k / nx) * step;
      if (o_addr_valid === 1'b1) begin
        r = beat / 24; c = beat % 24;
        exp_addr = (ey + r) * iw + ex + c;
        exp_eot  = (c == 23) ? ((r == 23) ? 3 : 1) : 0;
        checks++;
        if (o_addr !== 10'(exp_addr) || o_eot !== 2'(exp_eot)) begin
          errors++;
          $display("FAIL %s beat w%0d b%0d: addr=%0d eot=%b, want %0d %b", tag, k, beat, o_addr, o_eot, exp_addr, 2'(exp_eot));
        end
      end
      if (o_sum_ready === 1'b1) begin
        if (wait_cnt == 0) begin
          checks++;
          if (beat != 576) begin
            errors++;
            $display("FAIL %s beats_per_window w%0d: got %0d, want 576", tag, k, beat);
          end
        end
        wait_cnt++;
      end
      if (o_res_valid === 1'b1) begin
        checks++;
        if (o_res_x !== 5'(ex) || o_res_y !== 5'(ey) || o_res_sum !== sum_of(k)) begin
          errors++;
          $display("FAIL %s result %0d: x=%0d y=%0d sum=%h, want %0d %0d %h", tag, k, o_res_x, o_res_y, o_res_sum, ex, ey, sum_of(k));
        end
      end
      if (o_done === 1'b1) begin
        checks++;
        if (k != nx * ny) begin
          errors++;
          $display("FAIL %s done_count: got %0d results, want %0d", tag, k, nx * ny);
        end
        fin = 1;
      end
      pk = poke && ((k == 0 && beat == 100) || (k == 2 && o_res_valid === 1'b1));
      if (use_b) b_start = pk; else a_start = pk;
      addr_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      res_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      sum_valid  = (o_sum_ready === 1'b1) && (wait_cnt >= 2);
      sum_data   = sum_of(k);
      stall_a = (o_addr_valid === 1'b1) && !addr_ready;
      h_addr = o_addr; h_eot = o_eot;
      if (o_addr_valid === 1'b1 && addr_ready) beat++;
      stall_r = (o_res_valid === 1'b1) && !res_ready;
      h_x = o_res_x; h_y = o_res_y; h_sum = o_res_sum;
      if (o_res_valid === 1'b1 && res_ready) begin
        k++; beat = 0; wait_cnt = 0;
      end
      @(posedge clk); #1;
    end
    a_start = 1'b0; b_start = 1'b0; sum_valid = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL %s timeout: no done, %0d results seen", tag, k);
    end
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: done=%b busy=%b one cycle later, want 0 0", tag, o_done, o_busy);
    end
`ifdef WINDOW_SCAN_CTRL_CNT_EN
    checks++;
    if ((use_b ? int'(b_cnt) : int'(a_cnt)) != nx * ny) begin
      errors++;
      $display("FAIL %s win_cnt: got %0d, want %0d", tag, use_b ? int'(b_cnt) : int'(a_cnt), nx * ny);
    end
`endif
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_addr_valid !== 1'b0 || o_addr !== 10'd0 ||
          o_eot !== 2'b00 || o_sum_ready !== 1'b0 || o_res_valid !== 1'b0 ||
          o_res_x !== 5'd0 || o_res_y !== 5'd0 || o_res_sum !== 28'd0) begin
        errors++;
        $display("FAIL reset_state dut%0d: busy=%b done=%b av=%b addr=%0d eot=%b sr=%b rv=%b x=%0d y=%0d sum=%h, want all 0",
                 s, o_busy, o_done, o_addr_valid, o_addr, o_eot, o_sum_ready, o_res_valid, o_res_x, o_res_y, o_res_sum);
      end
    end
  endtask

  task automatic test_scan_basic();
    run_scan(0, 26, 3, 2, 1, 0, 0, "basic");
  endtask

  task automatic test_backpressure();
    run_scan(0, 26, 3, 2, 1, 1, 0, "backpressure");
  endtask

  task automatic test_step4();
    run_scan(1, 30, 2, 1, 4, 0, 0, "step4");
  endtask

  task automatic test_start_ignored();
    run_scan(0, 26, 3, 2, 1, 0, 1, "start_ignored");
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    addr_ready = 1'b1; res_ready = 1'b1; sum_valid = 1'b0;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (o_addr_valid !== 1'b1 || o_addr !== 10'd108) begin
      errors++;
      $display("FAIL reset_mid pre_beat100: v=%b addr=%0d, want 1 108", o_addr_valid, o_addr);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_addr_valid !== 1'b0 || o_addr !== 10'd0 ||
        o_eot !== 2'b00 || o_sum_ready !== 1'b0 || o_res_valid !== 1'b0 ||
        o_res_x !== 5'd0 || o_res_y !== 5'd0 || o_res_sum !== 28'd0) begin
      errors++;
      $display("FAIL reset_mid state: busy=%b done=%b av=%b addr=%0d eot=%b sr=%b rv=%b x=%0d y=%0d sum=%h, want all 0",
               o_busy, o_done, o_addr_valid, o_addr, o_eot, o_sum_ready, o_res_valid, o_res_x, o_res_y, o_res_sum);
    end
`ifdef WINDOW_SCAN_CTRL_CNT_EN
    checks++;
    if (a_cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid win_cnt: got %0d, want 0", a_cnt);
    end
`endif
    @(posedge clk); #1;
    run_scan(0, 26, 3, 2, 1, 0, 0, "rescan");
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; b_start = 1'b0; sel = 1'b0;
    addr_ready = 1'b0; sum_valid = 1'b0; res_ready = 1'b0; sum_data = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_scan_basic();
    test_backpressure();
    test_step4();
    test_reset_mid();
    test_start_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
